// File: rtl/trans_pkg.sv
// Shared definitions for the transaction dispatcher and the validator it feeds.
package trans_pkg;

    localparam int TRANS_W         = 128;
    localparam int BIT_BLOCK_START = 9;

    typedef logic [TRANS_W-1:0] trans_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2,
        WAIT  = 2'd3
    } disp_state_t;

endpackage

// File: rtl/trans_dispatcher_if.sv
// Requester-side and validator-side signals of the dispatcher, grouped as one bus.
interface trans_dispatcher_if
    import trans_pkg::*;
#(
    parameter int N_REQ = 4
);
    trans_t [N_REQ-1:0] req_data_i;
    logic   [N_REQ-1:0] req_valid_i;
    logic   [N_REQ-1:0] req_ready_o;
    trans_t             dn_data_o;
    logic               dn_valid_o;
    logic               dn_ready_i;
    logic               acc_valid_i;

    // Requester push: req_valid_i[k] && req_ready_o[k] at a rising edge.
    // Downstream transfer: dn_valid_o && dn_ready_i at a rising edge;
    // dn_data_o is held stable while dn_valid_o is high.
    modport slave (
        input  req_data_i, req_valid_i, dn_ready_i, acc_valid_i,
        output req_ready_o, dn_data_o, dn_valid_o
    );

    modport master (
        output req_data_i, req_valid_i, dn_ready_i, acc_valid_i,
        input  req_ready_o, dn_data_o, dn_valid_o
    );
endinterface

// File: rtl/trans_fifo.sv
// Show-ahead FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module trans_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata   = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
    assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; it is only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/trans_dispatcher.sv
// Round-robin scheduler feeding one transaction at a time into the validator,
// with saturating issued/accepted counters.
module trans_dispatcher
    import trans_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    trans_dispatcher_if.slave  bus,
    output logic [CNT_W-1:0]   cnt_issued_o,
    output logic [CNT_W-1:0]   cnt_accepted_o,
    output logic [1:0]         state_o
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_OFFER = OFFER;
    localparam logic [1:0] S_HOLD  = HOLD;
    localparam logic [1:0] S_WAIT  = WAIT;

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    trans_t           dn_data_q, dn_data_d;
    logic [CNT_W-1:0] issued_q, issued_d, accepted_q, accepted_d;

    logic [N_REQ-1:0] push, pop, full, empty;
    trans_t           fifo_rdata [N_REQ];
    logic             gnt_found;
    logic [GW-1:0]    gnt_idx;

    assign push            = bus.req_valid_i & ~full;
    assign bus.req_ready_o = ~full;
    assign bus.dn_valid_o  = (state_q == S_OFFER);
    assign bus.dn_data_o   = dn_data_q;
    assign cnt_issued_o    = issued_q;
    assign cnt_accepted_o  = accepted_q;
    assign state_o         = state_q;

    for (genvar k = 0; k < N_REQ; k++) begin : g_fifo
        trans_fifo #(.W(TRANS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .wdata (bus.req_data_i[k]),
            .rdata (fifo_rdata[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // Search upward from the port after last_grant, wrapping, first non-empty wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!gnt_found && !empty[(int'(last_grant_q) + i) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = GW'((int'(last_grant_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (state_q == S_IDLE && gnt_found) pop[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dn_data_d    = dn_data_q;
        issued_d     = issued_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    dn_data_d    = fifo_rdata[gnt_idx];
                    last_grant_d = gnt_idx;
                    state_d      = S_OFFER;
                end
            end
            S_OFFER: begin
                if (bus.dn_ready_i) begin
                    state_d = S_HOLD;
                    if (issued_q != '1) issued_d = issued_q + 1'b1;
                end
            end
            // One dead cycle so the validator can drop its idle indication.
            S_HOLD:  state_d = S_WAIT;
            S_WAIT:  if (bus.dn_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        accepted_d = (bus.acc_valid_i && accepted_q != '1) ? accepted_q + 1'b1 : accepted_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(N_REQ - 1);
            dn_data_q    <= '0;
            issued_q     <= '0;
            accepted_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dn_data_q    <= dn_data_d;
            issued_q     <= issued_d;
            accepted_q   <= accepted_d;
        end
    end
endmodule

// File: tb/tb_trans_dispatcher.sv
// Directed bench for trans_dispatcher: arbitration order, FIFO backpressure,
// offer stall, counter saturation and asynchronous reset.
module tb_trans_dispatcher;
    import trans_pkg::*;

    localparam int N_REQ      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] cnt_issued, cnt_accepted;
    logic [1:0]       state_dbg;
    logic             tb_ready = 1'b0;
    logic             model_en = 1'b0;
    logic             model_ready = 1'b1;
    logic             xfer_seen = 1'b0;
    int               busy = 0;
    int               checks = 0;
    int               errors = 0;
    trans_t           got_q[$];
    trans_t           exp_q[$];

    trans_dispatcher_if #(.N_REQ(N_REQ)) bus();

    trans_dispatcher #(.N_REQ(N_REQ), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .cnt_issued_o   (cnt_issued),
        .cnt_accepted_o (cnt_accepted),
        .state_o        (state_dbg)
    );

    always #5 clk = ~clk;

    assign bus.dn_ready_i = model_en ? model_ready : tb_ready;

    // Record every transfer; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.dn_valid_o && bus.dn_ready_i) begin
            got_q.push_back(bus.dn_data_o);
            xfer_seen = 1'b1;
        end
    end

    // Validator model: busy for 3 cycles after each accepted word.
    always @(posedge clk) begin
        #1;
        if (model_en) begin
            if (xfer_seen) begin
                model_ready = 1'b0;
                busy = 3;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) model_ready = 1'b1;
            end
        end
        xfer_seen = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.acc_valid_i = 1'b0;
        tb_ready    = 1'b0;
        model_en    = 1'b0;
        model_ready = 1'b1;
        busy        = 0;
        tick();
        tick();
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input int k, input trans_t d);
        bus.req_valid_i[k] = 1'b1;
        bus.req_data_i[k]  = d;
        tick();
        bus.req_valid_i[k] = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 300) begin
            tick();
            cyc++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout got %0d words want %0d", name, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
        checks++;
        if (bus.req_ready_o !== 4'hF) begin errors++; $display("FAIL reset_ready got %h want f", bus.req_ready_o); end
        checks++;
        if (bus.dn_valid_o !== 1'b0) begin errors++; $display("FAIL reset_dn_valid got %b want 0", bus.dn_valid_o); end
        checks++;
        if (bus.dn_data_o !== '0) begin errors++; $display("FAIL reset_dn_data got %h want 0", bus.dn_data_o); end
        checks++;
        if (cnt_issued !== '0) begin errors++; $display("FAIL reset_issued got %0d want 0", cnt_issued); end
        checks++;
        if (cnt_accepted !== '0) begin errors++; $display("FAIL reset_accepted got %0d want 0", cnt_accepted); end
    endtask

    task automatic test_single();
        trans_t d;
        d = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        do_reset();
        tb_ready = 1'b1;
        push_word(2, d);
        checks++;
        if (bus.dn_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_t got %b want 0", bus.dn_valid_o); end
        checks++;
        if (bus.req_ready_o[2] !== 1'b1) begin errors++; $display("FAIL single_ready2 got %b want 1", bus.req_ready_o[2]); end
        tick();
        checks++;
        if (bus.dn_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid_t1 got %b want 1", bus.dn_valid_o); end
        checks++;
        if (bus.dn_data_o !== d) begin errors++; $display("FAIL single_data got %h want %h", bus.dn_data_o, d); end
        tick();
        checks++;
        if (cnt_issued !== 4'd1) begin errors++; $display("FAIL single_issued got %0d want 1", cnt_issued); end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== d) begin
            errors++;
            $display("FAIL single_xfer got %0d words first %h want 1 word %h", got_q.size(), got_q[0], d);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        model_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N_REQ; k++) begin
                bus.req_valid_i[k] = 1'b1;
                bus.req_data_i[k]  = trans_t'(32'hA0 + 16 * r + k);
                exp_q.push_back(trans_t'(32'hA0 + 16 * r + k));
            end
            tick();
            bus.req_valid_i = '0;
            wait_got(4 * (r + 1), "rr");
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rr_order[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (cnt_issued !== 4'd8) begin errors++; $display("FAIL rr_issued got %0d want 8", cnt_issued); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        tb_ready = 1'b1;
        push_word(0, trans_t'(32'h55));
        tick();
        tick();
        tb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.req_ready_o[1] !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready[%0d] got %b want %b", i, bus.req_ready_o[1], (i < 4));
            end
            if (i < 4) exp_q.push_back(trans_t'(32'h10 + i));
            bus.req_valid_i[1] = 1'b1;
            bus.req_data_i[1]  = trans_t'(32'h10 + i);
            tick();
        end
        bus.req_valid_i = '0;
        checks++;
        if (bus.req_ready_o[1] !== 1'b0) begin errors++; $display("FAIL full_ready_end got %b want 0", bus.req_ready_o[1]); end
        tb_ready = 1'b1;
        wait_got(5, "full_drain");
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (got_q.size() != 5) begin errors++; $display("FAIL full_count got %0d want 5", got_q.size()); end
        checks++;
        if (got_q[0] !== trans_t'(32'h55)) begin errors++; $display("FAIL full_first got %h want 55", got_q[0]); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i + 1] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_order[%0d] got %h want %h", i, got_q[i + 1], exp_q[i]);
            end
        end
        checks++;
        if (bus.req_ready_o[1] !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b want 1", bus.req_ready_o[1]); end
    endtask

    task automatic test_offer_stall();
        trans_t d;
        d = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_0000_0200};
        do_reset();
        push_word(3, d);
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.dn_valid_o !== 1'b1 || bus.dn_data_o !== d || cnt_issued !== 4'd0) begin
                errors++;
                $display("FAIL stall[%0d] got valid %b data %h issued %0d want 1 %h 0",
                         i, bus.dn_valid_o, bus.dn_data_o, cnt_issued, d);
            end
            tick();
        end
        tb_ready = 1'b1;
        bus.acc_valid_i = 1'b1;
        tick();
        tb_ready = 1'b0;
        bus.acc_valid_i = 1'b0;
        checks++;
        if (cnt_issued !== 4'd1) begin errors++; $display("FAIL stall_issued got %0d want 1", cnt_issued); end
        checks++;
        if (cnt_accepted !== 4'd1) begin errors++; $display("FAIL stall_accepted got %0d want 1", cnt_accepted); end
        checks++;
        if (bus.dn_valid_o !== 1'b0) begin errors++; $display("FAIL stall_hold_valid got %b want 0", bus.dn_valid_o); end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== d) begin
            errors++;
            $display("FAIL stall_xfer got %0d words first %h want 1 word %h", got_q.size(), got_q[0], d);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.acc_valid_i = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (cnt_accepted !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", cnt_accepted); end
        for (int i = 0; i < 3; i++) tick();
        bus.acc_valid_i = 1'b0;
        checks++;
        if (cnt_accepted !== 4'd15) begin errors++; $display("FAIL sat_17 got %0d want 15", cnt_accepted); end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        for (int k = 0; k < N_REQ; k++) begin
            bus.req_valid_i[k] = 1'b1;
            bus.req_data_i[k]  = trans_t'(32'hE0 + k);
        end
        bus.acc_valid_i = 1'b1;
        tick();
        bus.req_valid_i = '0;
        bus.acc_valid_i = 1'b0;
        tick();
        checks++;
        if (bus.dn_valid_o !== 1'b1 || cnt_accepted !== 4'd1) begin
            errors++;
            $display("FAIL rmo_pre got valid %b accepted %0d want 1 1", bus.dn_valid_o, cnt_accepted);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dn_valid_o !== 1'b0) begin errors++; $display("FAIL rmo_valid got %b want 0", bus.dn_valid_o); end
        checks++;
        if (bus.req_ready_o !== 4'hF) begin errors++; $display("FAIL rmo_ready got %h want f", bus.req_ready_o); end
        checks++;
        if (cnt_issued !== '0 || cnt_accepted !== '0) begin
            errors++;
            $display("FAIL rmo_counters got %0d %0d want 0 0", cnt_issued, cnt_accepted);
        end
        checks++;
        if (state_dbg !== 2'd0) begin errors++; $display("FAIL rmo_state got %0d want 0", state_dbg); end
        tick();
        rst_n = 1'b1;
        got_q.delete();
        model_ready = 1'b1;
        busy = 0;
        model_en = 1'b1;
        bus.req_valid_i[0] = 1'b1;
        bus.req_data_i[0]  = trans_t'(32'hC0);
        bus.req_valid_i[3] = 1'b1;
        bus.req_data_i[3]  = trans_t'(32'hC3);
        tick();
        bus.req_valid_i = '0;
        wait_got(2, "rmo");
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL rmo_count got %0d want 2", got_q.size()); end
        checks++;
        if (got_q[0] !== trans_t'(32'hC0)) begin errors++; $display("FAIL rmo_first got %h want c0", got_q[0]); end
        checks++;
        if (got_q[1] !== trans_t'(32'hC3)) begin errors++; $display("FAIL rmo_second got %h want c3", got_q[1]); end
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.acc_valid_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_offer_stall();
        test_saturation();
        test_reset_mid_offer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trans_dispatcher.md
# trans_dispatcher

Input scheduler in front of the transaction validator. It accepts 128-bit transaction words from `N_REQ` independent requesters and buffers each requester in its own small FIFO. A round-robin arbiter serialises the buffered words onto the single validator input, issuing one transaction at a time and waiting for the validator to return to idle before issuing the next. It also keeps saturating issued/accepted counters for the status path.

## Interface
Parameters:
- `N_REQ`, 4: number of requester ports (2..8).
- `FIFO_DEPTH`, 4: entries per requester FIFO; power of two, ≥2.
- `CNT_W`, 32: width of statistics counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `req_data_i`  in  N_REQ×128  transaction word per requester, same field layout as the validator input (bit 9 = block start).
- `req_valid_i`  in  N_REQ  word present on port k.
- `req_ready_o`  out  N_REQ  port k FIFO not full.
- `dn_data_o`  out  128  word offered to the validator.
- `dn_valid_o`  out  1  offer valid.
- `dn_ready_i`  in  1  validator idle (in its wait-for-transaction state).
- `acc_valid_i`  in  1  validator success pulse (its `valid_o`).
- `cnt_issued_o`  out  CNT_W  transactions handed to the validator.
- `cnt_accepted_o`  out  CNT_W  `acc_valid_i` pulses seen.

## Operation
- Port k push: `req_valid_i[k] && req_ready_o[k]` writes `req_data_i[k]` into FIFO k. `req_ready_o[k] = !full_k`, derived from registered occupancy only.
- FSM states:
  - IDLE: if any FIFO is non-empty, grant the first non-empty port after `last_grant`, searching upward and wrapping modulo N_REQ. Pop it into the `dn_data_o` register, set `last_grant` to that port, go to OFFER. If all FIFOs are empty, stay in IDLE.
  - OFFER: `dn_valid_o=1`, `dn_data_o` stable. Transfer happens when `dn_ready_i` is high at the rising edge. On transfer go to HOLD and increment `cnt_issued_o`. Otherwise stay in OFFER.
  - HOLD: exactly one cycle with `dn_valid_o=0`, which lets the validator drop `dn_ready_i`. Then go to WAIT.
  - WAIT: stay until `dn_ready_i=1`, then go to IDLE.
- Only one transaction is ever in the validator. This guarantees the validator never samples a word while it is busy.
- Words are forwarded bit-exact; bit 9 (block start) is not modified or interpreted.
- Each FIFO preserves per-port order. Ordering across ports is round-robin.
- Counters saturate at all-ones and never wrap.
- `cnt_accepted_o` increments on every cycle with `acc_valid_i=1`, independent of FSM state.

## Timing
Reset values:
- FSM = IDLE.
- `last_grant` = N_REQ-1, so port 0 has first priority.
- All FIFOs empty.
- `req_ready_o` = all ones.
- `dn_valid_o` = 0, `dn_data_o` = 0.
- Both counters = 0.

Latency and throughput:
- A push at edge t makes FIFO k non-empty after t.
- The grant and pop happen at edge t+1.
- `dn_valid_o` is high from t+1 (registered), so the earliest transfer is at edge t+2.
- Minimum issue-to-issue spacing is 4 cycles: OFFER, HOLD, WAIT/IDLE, OFFER. In practice the spacing is bounded by validator busy time.

Boundary conditions:
- A push to a full FIFO is impossible because ready is low. Push and pop on the same edge at occupancy FIFO_DEPTH-1 or lower are both performed, and occupancy is unchanged.
- A pop and a new push on the same port in the same cycle are handled correctly at any non-full occupancy.
- Only one port is popped per cycle.
- `dn_ready_i` low throughout OFFER: the word is held indefinitely and `dn_data_o` must not change.
- `acc_valid_i` coincident with an issue: both counters increment in that cycle.
- `rst_n` asserted mid-OFFER: `dn_valid_o` drops asynchronously and the buffered words are discarded.

## Structure
Shared package `trans_pkg`:
- `TRANS_W` = 128 and `BIT_BLOCK_START` = 9, shared with the validator.
- Typedef `trans_t` (logic [127:0]).
- Enum `disp_state_t` {IDLE, OFFER, HOLD, WAIT}.

Sub-module `trans_fifo`:
- Parameterised by width and depth, instantiated N_REQ times.
- Pointers are one bit wider than the address, so wrap is unambiguous.
- Exposes `full`, `empty`, `push`, `pop`, `rdata` (show-ahead).

The arbiter and FSM live in `trans_dispatcher`.

## Test plan
- Single word, port 2, `dn_ready_i` high: `dn_valid_o` rises at t+1 and the transfer happens at t+2 with identical data. `cnt_issued_o`=1. Port 2 ready stays 1.
- All four ports each push word 0xA0..0xA3 at the same edge, `dn_ready_i` held high except during the modelled 3-cycle busy: the issue order is port 0,1,2,3. After that, the next round of simultaneous pushes also issues 0,1,2,3.
- Port 1 pushes 5 words with `dn_ready_i` low: `req_ready_o[1]` drops after the 4th push (the 4th word is accepted, the 5th is blocked). After `dn_ready_i` rises, the words drain in push order.
- Offer stall: hold `dn_ready_i` low for 20 cycles during OFFER: `dn_valid_o` stays high and data is constant. The counter increments only at the transfer edge.
- Counter saturation with CNT_W=4: 17 `acc_valid_i` pulses leave `cnt_accepted_o`=15.
- Pulse `rst_n` low while in OFFER with 3 words buffered: `dn_valid_o` goes to 0 immediately, all ready bits go to 1, counters read 0, and port 0 has priority again.
